// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register file with debug display and dump engine.
//   - default data/address widths
//   - index of the hard-wired zero register
//   - dump FSM state encoding
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_LOAD = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Streams every register of the array over a valid/ready interface.
// Each beat is a fresh snapshot: the register is read in a LOAD cycle and the
// beat is then offered in SEND until accepted (one beat per two cycles).
//
// Ports
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   dump_start       single-cycle request, honoured only in IDLE
//   dump_ready       consumer accepts the current beat
//   rd_addr/rd_data  internal read port into the register array
//   dump_busy        high from the cycle after start acceptance until done
//   dump_valid/addr/data  current beat
//   dump_done        one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NREGS - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d = DUMP_LOAD;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      DUMP_LOAD: begin
        data_d  = rd_data;
        addr_d  = ptr_q;
        valid_d = 1'b1;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (valid_q && dump_ready) begin
          valid_d = 1'b0;
          // Terminal check comes before the increment so ptr never wraps.
          if (ptr_q == LAST_PTR) begin
            state_d = DUMP_DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = DUMP_LOAD;
          end
        end
      end
      DUMP_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DUMP_IDLE;
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr    = ptr_q;
  assign dump_busy  = busy_q;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/regfile_dbg.sv
// -----------------------------------------------------------------------------
// regfile_dbg
// GPR array with two combinational read ports and one write port for the
// datapath, a registered display read port and a register dump engine.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   ra1/rd1, ra2/rd2    combinational read ports (no write bypass)
//   we/wa/wd            write port
//   dis/add/A           display port, A <= dis ? R[add] : 0
//   dump_*              dump request, valid/ready beat stream, busy/done
// Addresses >= NREGS read as 0 and are never written. With ZERO_REG=1,
// register 0 reads as 0 and writes to it are dropped.
// -----------------------------------------------------------------------------
module regfile_dbg
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              dis,
  input  logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] A,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;

  // True for a register index that holds real state.
  function automatic logic is_storage(input int idx);
    return !(ZERO_REG != 0 && idx == REG_ZERO);
  endfunction

  // Shared read rule for all ports: out-of-range and zero-register reads give 0.
  function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr == ADDR_W'(i) && is_storage(i)) val = regs_q[i];
    end
    return val;
  endfunction

  // Only indices below NREGS are matched, so out-of-range writes fall away.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && wa == ADDR_W'(i) && is_storage(i)) regs_d[i] = wd;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd1 = read_reg(ra1);
  assign rd2 = read_reg(ra2);

  // Display read uses pre-edge contents, so a colliding write shows next time.
  assign a_d = dis ? read_reg(add) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) a_q <= '0;
    else        a_q <= a_d;
  end

  assign A = a_q;

  assign dump_rd_data = read_reg(dump_rd_addr);

  regfile_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_dump_ctrl (
    .clock      (clock),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rd_addr    (dump_rd_addr),
    .rd_data    (dump_rd_data),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

endmodule
